adj_aggregator: RTL and testbench

- Sequential aggregation stage that sits directly downstream of the FM×WM product stage and wraps the row adder.
- Walks the COO adjacency edge list one edge per two cycles and accumulates neighbour rows of the FM×WM matrix into an output row buffer: self-loop init, then symmetric edge sums.
- Hands the aggregated matrix, and optionally per-node class indices, to the result writer.

---
 rtl/adj_aggregator_pkg.sv | 24 ++
 rtl/adj_aggregator_row_adder.sv | 21 ++
 rtl/adj_aggregator.sv | 206 ++++++++++++++++++++
 tb/tb_adj_aggregator.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adj_aggregator_pkg.sv
// Shared definitions for the adjacency aggregation stage: FSM state
// encoding, default matrix dimensions and the row type used for one
// FM x WM row.
package adj_aggregator_pkg;

    localparam int DEF_FEATURE_ROWS    = 6;
    localparam int DEF_WEIGHT_COLS     = 3;
    localparam int DEF_DOT_PROD_WIDTH  = 16;
    localparam int DEF_COO_NUM_OF_COLS = 6;

    // ARGMAX is only entered when the argmax option is compiled in.
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_ACC,
        S_ARGMAX,
        S_DONE
    } state_t;

    // One matrix row at the default dimensions: WEIGHT_COLS elements.
    typedef logic [DEF_WEIGHT_COLS-1:0][DEF_DOT_PROD_WIDTH-1:0] row_t;

endpackage

// File: rtl/adj_aggregator_row_adder.sv
// Row adder: element-wise unsigned sum of two matrix rows. Each column
// wraps modulo 2^WIDTH; there is no carry between columns.
module adj_aggregator_row_adder
    import adj_aggregator_pkg::*;
#(
    parameter int COLS  = DEF_WEIGHT_COLS,
    parameter int WIDTH = DEF_DOT_PROD_WIDTH
) (
    input  logic [COLS*WIDTH-1:0] i_a,
    input  logic [COLS*WIDTH-1:0] i_b,
    output logic [COLS*WIDTH-1:0] o_sum
);

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            assign o_sum[gi*WIDTH +: WIDTH] = i_a[gi*WIDTH +: WIDTH] + i_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

endmodule

// File: rtl/adj_aggregator.sv
// Adjacency aggregator. Walks the COO edge list (one edge per FETCH/ACC
// pair) and accumulates neighbour rows of the FM x WM matrix into the
// output row buffer, starting from the self-loop copy made in INIT.
// Optional feature macro: AGG_ARGMAX_EN adds the ARGMAX state and the
// per-row class index output o_max_addr.
module adj_aggregator
    import adj_aggregator_pkg::*;
#(
    parameter int FEATURE_ROWS    = DEF_FEATURE_ROWS,
    parameter int WEIGHT_COLS     = DEF_WEIGHT_COLS,
    parameter int DOT_PROD_WIDTH  = DEF_DOT_PROD_WIDTH,
    parameter int COO_NUM_OF_COLS = DEF_COO_NUM_OF_COLS,
    parameter int FEATURE_WIDTH   = $clog2(FEATURE_ROWS),
    parameter int COO_ADDR_WIDTH  = $clog2(COO_NUM_OF_COLS)
`ifdef AGG_ARGMAX_EN
    ,
    parameter int WEIGHT_WIDTH    = $clog2(WEIGHT_COLS)
`endif
) (
    input  logic                                               i_clk,
    input  logic                                               i_rst,
    input  logic                                               i_start,
    input  logic [FEATURE_ROWS*WEIGHT_COLS*DOT_PROD_WIDTH-1:0] i_fm_wm,
    output logic [COO_ADDR_WIDTH-1:0]                          o_coo_address,
    input  logic [2*FEATURE_WIDTH-1:0]                         i_coo,
    output logic [FEATURE_ROWS*WEIGHT_COLS*DOT_PROD_WIDTH-1:0] o_fm_wm_adj,
    output logic                                               o_busy,
    output logic                                               o_done
`ifdef AGG_ARGMAX_EN
    ,
    output logic [FEATURE_ROWS*WEIGHT_WIDTH-1:0]               o_max_addr
`endif
);

    typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] agg_row_t;

    state_t                                r_state;
    agg_row_t [FEATURE_ROWS-1:0]           r_adj;
    logic [COO_ADDR_WIDTH-1:0]             r_edge;
    logic                                  r_busy;
    logic                                  r_done;

    agg_row_t [FEATURE_ROWS-1:0]           w_fm;
    logic [FEATURE_WIDTH-1:0]              w_src;
    logic [FEATURE_WIDTH-1:0]              w_dst;
    logic                                  w_edge_ok;
    logic                                  w_last;
    agg_row_t                              w_adj_src;
    agg_row_t                              w_adj_dst;
    agg_row_t                              w_fm_src;
    agg_row_t                              w_fm_dst;
    agg_row_t                              w_src_sum;
    agg_row_t                              w_dst_sum;

    assign w_fm  = i_fm_wm;
    assign w_src = i_coo[2*FEATURE_WIDTH-1:FEATURE_WIDTH];
    assign w_dst = i_coo[FEATURE_WIDTH-1:0];

    // An edge touching a node outside the matrix is dropped entirely.
    assign w_edge_ok = (32'(w_src) < FEATURE_ROWS) && (32'(w_dst) < FEATURE_ROWS);
    assign w_last    = (r_edge == COO_ADDR_WIDTH'(COO_NUM_OF_COLS - 1));

    // Row selection for both edge endpoints; out-of-range indices select zero rows.
    always_comb begin
        w_adj_src = '0;
        w_adj_dst = '0;
        w_fm_src  = '0;
        w_fm_dst  = '0;
        for (int r = 0; r < FEATURE_ROWS; r++) begin
            if (FEATURE_WIDTH'(r) == w_src) begin
                w_adj_src = r_adj[r];
                w_fm_src  = w_fm[r];
            end
            if (FEATURE_WIDTH'(r) == w_dst) begin
                w_adj_dst = r_adj[r];
                w_fm_dst  = w_fm[r];
            end
        end
    end

    // dst row gathers the src feature row, src row gathers the dst feature row.
    adj_aggregator_row_adder #(
        .COLS  (WEIGHT_COLS),
        .WIDTH (DOT_PROD_WIDTH)
    ) u_dst_add (
        .i_a   (w_adj_dst),
        .i_b   (w_fm_src),
        .o_sum (w_dst_sum)
    );

    adj_aggregator_row_adder #(
        .COLS  (WEIGHT_COLS),
        .WIDTH (DOT_PROD_WIDTH)
    ) u_src_add (
        .i_a   (w_adj_src),
        .i_b   (w_fm_dst),
        .o_sum (w_src_sum)
    );

`ifdef AGG_ARGMAX_EN
    logic [FEATURE_ROWS-1:0][WEIGHT_WIDTH-1:0] r_max;
    logic [FEATURE_ROWS-1:0][WEIGHT_WIDTH-1:0] w_argmax;

    genvar gi;
    generate
        for (gi = 0; gi < FEATURE_ROWS; gi++) begin : g_argmax
            logic [DOT_PROD_WIDTH-1:0] w_best;
            // Strict greater-than keeps the lowest column index on ties.
            always_comb begin
                w_best       = r_adj[gi][0];
                w_argmax[gi] = '0;
                for (int c = 1; c < WEIGHT_COLS; c++) begin
                    if (r_adj[gi][c] > w_best) begin
                        w_best       = r_adj[gi][c];
                        w_argmax[gi] = WEIGHT_WIDTH'(c);
                    end
                end
            end
        end
    endgenerate

    assign o_max_addr = r_max;
`endif

    // Control FSM with registered status outputs and the accumulation buffer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_adj   <= '0;
            r_edge  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef AGG_ARGMAX_EN
            r_max   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_INIT;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_INIT: begin
                    r_adj   <= w_fm;
                    r_edge  <= '0;
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    if (w_edge_ok) begin
                        for (int r = 0; r < FEATURE_ROWS; r++) begin
                            // A self-loop hits the dst branch only, so it is added once.
                            if (FEATURE_WIDTH'(r) == w_dst) begin
                                r_adj[r] <= w_dst_sum;
                            end else if (FEATURE_WIDTH'(r) == w_src) begin
                                r_adj[r] <= w_src_sum;
                            end
                        end
                    end
                    if (w_last) begin
`ifdef AGG_ARGMAX_EN
                        r_state <= S_ARGMAX;
`else
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_edge  <= r_edge + 1'b1;
                        r_state <= S_FETCH;
                    end
                end
`ifdef AGG_ARGMAX_EN
                S_ARGMAX: begin
                    r_max   <= w_argmax;
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
`endif
                S_DONE: begin
                    if (i_start) begin
                        r_state <= S_INIT;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_coo_address = r_edge;
    assign o_fm_wm_adj   = r_adj;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_adj_aggregator.sv
// Directed bench for adj_aggregator. Each run pushes the model's expected
// matrix and latency onto a scoreboard queue; the entry is popped and
// compared when done rises. Define AGG_ARGMAX_EN to cover the argmax path.
module tb_adj_aggregator;

    localparam int ROWS = 6;
    localparam int COLS = 3;
    localparam int W    = 16;
    localparam int NE   = 6;
    localparam int MW   = ROWS*COLS*W;
`ifdef AGG_ARGMAX_EN
    localparam int LAT  = 15;
`else
    localparam int LAT  = 14;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [MW-1:0]   fm_vec;
    logic [2:0]      coo_address;
    logic [5:0]      coo_q = 6'h3F;
    logic [MW-1:0]   adj_out;
    logic            busy;
    logic            done;
`ifdef AGG_ARGMAX_EN
    logic [ROWS*2-1:0] max_addr;
`endif

    logic [W-1:0]    fm_a [ROWS][COLS];
    logic [5:0]      coo_mem [NE];

    typedef struct {
        logic [MW-1:0] mat;
        int            lat;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adj_aggregator dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_fm_wm       (fm_vec),
        .o_coo_address (coo_address),
        .i_coo         (coo_q),
        .o_fm_wm_adj   (adj_out),
        .o_busy        (busy),
        .o_done        (done)
`ifdef AGG_ARGMAX_EN
        ,
        .o_max_addr    (max_addr)
`endif
    );

    // COO memory with one-cycle registered read
    always @(posedge clk) begin
        coo_q <= (coo_address < 3'(NE)) ? coo_mem[coo_address] : 6'h3F;
    end

    always_comb begin
        fm_vec = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                fm_vec[(r*COLS+c)*W +: W] = fm_a[r][c];
    end

    function automatic logic [MW-1:0] model();
        logic [W-1:0]  a [ROWS][COLS];
        logic [MW-1:0] v;
        int s, d;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                a[r][c] = fm_a[r][c];
        for (int e = 0; e < NE; e++) begin
            s = int'(coo_mem[e][5:3]);
            d = int'(coo_mem[e][2:0]);
            if (s < ROWS && d < ROWS) begin
                for (int c = 0; c < COLS; c++) begin
                    if (s == d) begin
                        a[s][c] = a[s][c] + fm_a[s][c];
                    end else begin
                        a[d][c] = a[d][c] + fm_a[s][c];
                        a[s][c] = a[s][c] + fm_a[d][c];
                    end
                end
            end
        end
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r*COLS+c)*W +: W] = a[r][c];
        return v;
    endfunction

    function automatic logic [W-1:0] elem(input int r, input int c);
        return adj_out[(r*COLS+c)*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_edge(input int i, input int s, input int d);
        coo_mem[i] = {3'(s), 3'(d)};
    endtask

    task automatic fill_out_of_range();
        for (int i = 0; i < NE; i++) set_edge(i, 7, 7);
    endtask

    // One aggregation run; glitch_at > 0 raises start again while busy.
    task automatic run_agg(input string tag, input int glitch_at);
        exp_t e;
        int   n;
        e.mat = model();
        e.lat = LAT;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            start = (glitch_at != 0 && n == glitch_at);
            if (glitch_at == 0 && n >= 2 && n <= 2*NE && (n % 2) == 0)
                chk({tag, "_addr"}, MW'(coo_address), MW'((n-2)/2));
        end while (!done && n < 200);
        start = 1'b0;
        e = sb.pop_front();
        chk({tag, "_latency"}, MW'(n), MW'(e.lat));
        chk({tag, "_matrix"}, adj_out, e.mat);
        chk({tag, "_busy"}, MW'(busy), MW'(0));
`ifdef AGG_ARGMAX_EN
        begin
            logic [ROWS*2-1:0] am;
            logic [W-1:0]      best;
            am = '0;
            for (int r = 0; r < ROWS; r++) begin
                best = e.mat[(r*COLS)*W +: W];
                for (int c = 1; c < COLS; c++) begin
                    if (e.mat[(r*COLS+c)*W +: W] > best) begin
                        best = e.mat[(r*COLS+c)*W +: W];
                        am[r*2 +: 2] = 2'(c);
                    end
                end
            end
            chk({tag, "_argmax"}, MW'(max_addr), MW'(am));
        end
`endif
        $display("txn %s: latency=%0d done=%0b", tag, n, done);
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                fm_a[r][c] = '0;
        fill_out_of_range();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out",  adj_out, '0);
        chk("rst_busy", MW'(busy), MW'(0));
        chk("rst_done", MW'(done), MW'(0));
        chk("rst_addr", MW'(coo_address), MW'(0));
`ifdef AGG_ARGMAX_EN
        chk("rst_max",  MW'(max_addr), MW'(0));
`endif
        rst = 1'b0;

        // Ring graph, row r = {r, r+1, r+2}
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                fm_a[r][c] = W'(r + c);
        for (int i = 0; i < NE; i++) set_edge(i, i, (i + 1) % ROWS);
        run_agg("ring", 0);
        chk("ring_r0c0", MW'(elem(0, 0)), MW'(6));
        chk("ring_r0c1", MW'(elem(0, 1)), MW'(9));
        chk("ring_r0c2", MW'(elem(0, 2)), MW'(12));

        // Reset asserted during ACC of edge 3
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_busy_before", MW'(busy), MW'(1));
        #1 rst = 1'b1;
        #1;
        chk("midrst_out",  adj_out, '0);
        chk("midrst_busy", MW'(busy), MW'(0));
        chk("midrst_done", MW'(done), MW'(0));
        chk("midrst_addr", MW'(coo_address), MW'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("midrst_idle", MW'(busy), MW'(0));
        run_agg("ring_after_rst", 0);

        // Self-loop plus out-of-range edges
        fill_out_of_range();
        set_edge(1, 2, 2);
        set_edge(2, 0, 6);
        set_edge(3, 6, 1);
        run_agg("self_loop", 0);
        for (int c = 0; c < COLS; c++)
            chk("self_r2", MW'(elem(2, c)), MW'(W'(2 * (2 + c))));
        chk("self_r0", MW'(elem(0, 0)), MW'(0));

        // Wrap-around on overflow
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                fm_a[r][c] = '0;
        fm_a[0][0] = 16'hFFFF;
        fm_a[1][0] = 16'h0001;
        fill_out_of_range();
        set_edge(0, 0, 1);
        run_agg("overflow", 0);
        chk("ovf_r0c0", MW'(elem(0, 0)), MW'(16'h0000));
        chk("ovf_r1c0", MW'(elem(1, 0)), MW'(16'h0000));

        // start while busy is ignored; start in DONE reruns identically
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                fm_a[r][c] = W'(3 * r + 7 * c + 1);
        set_edge(0, 0, 3);
        set_edge(1, 5, 2);
        set_edge(2, 4, 4);
        set_edge(3, 1, 3);
        set_edge(4, 7, 0);
        set_edge(5, 2, 0);
        run_agg("busy_start", 5);
        run_agg("restart_done", 0);

        // Argmax row patterns (no valid edges, output equals input)
        fill_out_of_range();
        fm_a[0][0] = 7;  fm_a[0][1] = 9;  fm_a[0][2] = 9;
        fm_a[1][0] = 3;  fm_a[1][1] = 1;  fm_a[1][2] = 2;
        fm_a[2][0] = 1;  fm_a[2][1] = 1;  fm_a[2][2] = 1;
        fm_a[3][0] = 0;  fm_a[3][1] = 0;  fm_a[3][2] = 5;
        run_agg("argmax_rows", 0);
`ifdef AGG_ARGMAX_EN
        chk("argmax_r0", MW'(max_addr[1:0]), MW'(1));
        chk("argmax_r1", MW'(max_addr[3:2]), MW'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
